program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Parametrised successor to the fixed-program instruction pusher.
- Holds a writable program memory, loaded through a load port while stopped.
- Sequences instructions through a FETCH/EXEC state machine, with per-opcode latency set by parameters.
- Resolves conditional jumps against the 3-bit compare status and drives the instruction bus into the control unit.

Parameters:
INSTR_W, 32, instruction width; opcode is always instr[INSTR_W-1 -: 3]
PC_W, 6, program counter width; program depth DEPTH = 2**PC_W (localparam)
MOV_CYC, 7, EXEC cycles for opcode 001
ALU_CYC, 3, EXEC cycles for opcodes 010..101
CMP_CYC, 4, EXEC cycles for opcode 110
JMP_CYC, 4, EXEC cycles for opcode 111
NOP_CYC, 2, EXEC cycles for opcode 000 (all *_CYC >= 1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
load_en  in  1  write load_data into program memory at load_addr
load_addr  in  PC_W  program memory write address
load_data  in  INSTR_W  program memory write data
run  in  1  start pulse: begin at PC 0
stop  in  1  abort pulse: return to IDLE
status  in  3  compare flags {gt, ge, eq}
instruction  out  INSTR_W  current instruction to control unit, 0 when not executing
pc  out  PC_W  address of current or next instruction
issue  out  1  one-cycle pulse on the first EXEC cycle of each instruction
busy  out  1  high in FETCH or EXEC
halted  out  1  high in HALT

Behaviour:
- Reset (async): state=IDLE; instruction, pc, issue, busy, halted and the cycle counter = 0. Program memory is not reset.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE/HALT:
  - load_en writes mem[load_addr] <= load_data.
  - run (without stop) sets pc=0, clears halted, goes to FETCH.
- FETCH (1 cycle):
  - instruction <= mem[pc], cnt <= 1, issue <= 1, go to EXEC.
  - instruction reads 0 during FETCH.
- EXEC:
  - issue is high only in the first cycle; instruction is held stable.
  - cnt increments each cycle until cnt == LAT(opcode).
  - On that edge, pc is updated, instruction <= 0, and the FSM goes to FETCH.
  - Each instruction therefore occupies LAT+1 cycles.
- PC update:
  - Non-jump opcodes: pc+1, wrapping DEPTH-1 -> 0.
  - Opcode 111: cond = instr[INSTR_W-4 -: 3], target = instr[PC_W-1:0]. Status is sampled on the final EXEC cycle.
    - 001: taken if status[0]
    - 010: taken if status[1]
    - 100: taken if status[2]
    - any other cond: unconditional
    - Not taken: pc+1.
- HALT: opcode 000 with bit INSTR_W-4 set. On its final EXEC cycle the FSM enters HALT with halted=1; pc stays at the halt instruction.
- load_en is ignored in FETCH and EXEC.
- stop: from any state, next edge forces IDLE, instruction=0, issue=0; pc is kept. stop beats run when both are asserted.
- busy = (state==FETCH || state==EXEC), registered with the state.

Optional Feature:
- Macro: PROG_SEQ_CALL_EN.
- Defined:
  - Jump cond 011 = CALL: link <= pc+1 (wrapping), pc <= target.
  - Jump cond 101 = RET: pc <= link.
  - link is a single PC_W register, reset to 0. A nested CALL overwrites it.
- Undefined: cond 011 and 101 are unconditional jumps to target, and no link register exists.

Test Plan:
- Load mem[0]=MOV, mem[1]=ADD, mem[2]=HALT (0x1000_0000), pulse run -> issue at cycles 2, 10, 14 after run; halted=1 with pc=2 after 17 cycles; instruction=0 in HALT.
- mem[0]=CMP, mem[1]=JMP cond 001 target 5, status=3'b001 held -> pc=5 after the jump; repeat with status=3'b000 -> pc=2.
- Load mem[63]=ADD only, start with a JMP at 0 to target 63 -> after ADD, pc wraps to 0.
- Pulse stop during the 4th EXEC cycle of a MOV -> next cycle state IDLE, busy=0, instruction=0, pc unchanged; run and stop together from IDLE -> stays IDLE.
- Assert rst mid-EXEC -> all outputs 0 immediately without a clock edge; load_en during EXEC does not change mem (readback via a later run).
- With PROG_SEQ_CALL_EN: CALL at 4 to 10, RET at 10 -> pc 10 then 5; without the macro, the same program -> pc 10 then the RET target field.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer: programmable instruction sequencer.
// A writable program memory is loaded while stopped, then stepped
// through a FETCH/EXEC state machine. Each opcode has its own EXEC
// latency, and jumps are resolved against the 3-bit compare status.
// Optional macro PROG_SEQ_CALL_EN adds single-level CALL/RET through a
// link register (jump cond 011 = CALL, cond 101 = RET).
module program_sequencer #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 6,
  parameter int MOV_CYC = 7,
  parameter int ALU_CYC = 3,
  parameter int CMP_CYC = 4,
  parameter int JMP_CYC = 4,
  parameter int NOP_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               run,
  input  logic               stop,
  input  logic [2:0]         status,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic               issue,
  output logic               busy,
  output logic               halted
);

  localparam int DEPTH = 2**PC_W;
  localparam int MAX_A = (MOV_CYC > ALU_CYC) ? MOV_CYC : ALU_CYC;
  localparam int MAX_B = (CMP_CYC > JMP_CYC) ? CMP_CYC : JMP_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > NOP_CYC) ? MAX_C : NOP_CYC;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t             state, state_next;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] instruction_next;
  logic [PC_W-1:0]    pc_next, pc_inc, target, jump_pc;
  logic [CNT_W-1:0]   cnt, cnt_next, lat;
  logic               issue_next, busy_next, halted_next;
  logic [2:0]         opcode, cond;
  logic               is_halt, done;
`ifdef PROG_SEQ_CALL_EN
  logic [PC_W-1:0]    link, link_next;
`endif

  assign opcode  = instruction[INSTR_W-1 -: 3];
  assign cond    = instruction[INSTR_W-4 -: 3];
  assign target  = instruction[PC_W-1:0];
  assign pc_inc  = pc + PC_W'(1);
  assign is_halt = (opcode == 3'b000) && instruction[INSTR_W-4];
  assign done    = (cnt == lat);

  // Program memory: writable only while the sequencer is stopped.
  always_ff @(posedge clk) begin
    if (load_en && (state == IDLE || state == HALT))
      mem[load_addr] <= load_data;
  end

  // EXEC latency of the instruction currently held.
  always_comb begin
    lat = CNT_W'(NOP_CYC);
    case (opcode)
      3'b000:                         lat = CNT_W'(NOP_CYC);
      3'b001:                         lat = CNT_W'(MOV_CYC);
      3'b010, 3'b011, 3'b100, 3'b101: lat = CNT_W'(ALU_CYC);
      3'b110:                         lat = CNT_W'(CMP_CYC);
      default:                        lat = CNT_W'(JMP_CYC);
    endcase
  end

  // Successor address: jump resolution against the live status flags.
  always_comb begin
    jump_pc = pc_inc;
    if (opcode == 3'b111) begin
      case (cond)
        3'b001: jump_pc = status[0] ? target : pc_inc;
        3'b010: jump_pc = status[1] ? target : pc_inc;
        3'b100: jump_pc = status[2] ? target : pc_inc;
`ifdef PROG_SEQ_CALL_EN
        3'b101: jump_pc = link;
`endif
        default: jump_pc = target;
      endcase
    end
  end

  // Next-state and registered-output logic; stop overrides everything.
  always_comb begin
    state_next       = state;
    instruction_next = instruction;
    pc_next          = pc;
    cnt_next         = cnt;
    issue_next       = 1'b0;
`ifdef PROG_SEQ_CALL_EN
    link_next        = link;
`endif
    case (state)
      IDLE, HALT: begin
        if (run) begin
          pc_next    = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        instruction_next = mem[pc];
        cnt_next         = CNT_W'(1);
        issue_next       = 1'b1;
        state_next       = EXEC;
      end
      EXEC: begin
        if (done) begin
          instruction_next = '0;
          if (is_halt) begin
            state_next = HALT;
          end else begin
            pc_next    = jump_pc;
            state_next = FETCH;
`ifdef PROG_SEQ_CALL_EN
            if (opcode == 3'b111 && cond == 3'b011)
              link_next = pc_inc;
`endif
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    if (stop) begin
      state_next       = IDLE;
      instruction_next = '0;
      issue_next       = 1'b0;
      pc_next          = pc;
`ifdef PROG_SEQ_CALL_EN
      link_next        = link;
`endif
    end
    // busy/halted are registered images of the next state.
    busy_next   = (state_next == FETCH) || (state_next == EXEC);
    halted_next = (state_next == HALT);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instruction <= '0;
      pc          <= '0;
      cnt         <= '0;
      issue       <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
`ifdef PROG_SEQ_CALL_EN
      link        <= '0;
`endif
    end else begin
      state       <= state_next;
      instruction <= instruction_next;
      pc          <= pc_next;
      cnt         <= cnt_next;
      issue       <= issue_next;
      busy        <= busy_next;
      halted      <= halted_next;
`ifdef PROG_SEQ_CALL_EN
      link        <= link_next;
`endif
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: per-instruction latency/next-PC
// vectors plus hand-written multi-cycle sequences.
module tb_program_sequencer;
  localparam int IW = 32;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [PW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic          run = 1'b0;
  logic          stop = 1'b0;
  logic [2:0]    status = '0;
  logic [IW-1:0] instruction;
  logic [PW-1:0] pc;
  logic          issue, busy, halted;

  int tests = 0;
  int fails = 0;

  program_sequencer #(.INSTR_W(IW), .PC_W(PW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .run(run), .stop(stop), .status(status),
    .instruction(instruction), .pc(pc), .issue(issue), .busy(busy),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] instr;
    logic [2:0]    st;
    int            lat;
    logic [PW-1:0] npc;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [IW-1:0] data);
    load_en = 1'b1; load_addr = PW'(addr); load_data = data;
    step();
    load_en = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 64; i++) load(i, '0);
  endtask

  task automatic pulse_run();
    run = 1'b1; step(); run = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic wait_issue(input int lim, output int n, output bit got);
    n = 0; got = 1'b0;
    while (!got && n < lim) begin
      step(); n++; got = issue;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  got;
    int  iss_e[3];
    int  iss_n;
    logic [PW-1:0] exp_pcs[7];

    vecs[0]  = '{32'h0000_0000, 3'b000, 2, 6'd1};
    vecs[1]  = '{32'h2000_0000, 3'b000, 7, 6'd1};
    vecs[2]  = '{32'h4000_0000, 3'b000, 3, 6'd1};
    vecs[3]  = '{32'h6000_0000, 3'b000, 3, 6'd1};
    vecs[4]  = '{32'h8000_0000, 3'b000, 3, 6'd1};
    vecs[5]  = '{32'hA000_0000, 3'b000, 3, 6'd1};
    vecs[6]  = '{32'hC000_0000, 3'b000, 4, 6'd1};
    vecs[7]  = '{32'hE000_0009, 3'b000, 4, 6'd9};
    vecs[8]  = '{32'hE400_0011, 3'b001, 4, 6'd17};
    vecs[9]  = '{32'hE400_0011, 3'b110, 4, 6'd1};
    vecs[10] = '{32'hE800_0021, 3'b010, 4, 6'd33};
    vecs[11] = '{32'hE800_0021, 3'b101, 4, 6'd1};
    vecs[12] = '{32'hF000_002A, 3'b100, 4, 6'd42};
    vecs[13] = '{32'hF000_002A, 3'b011, 4, 6'd1};
    vecs[14] = '{32'hF800_0007, 3'b000, 4, 6'd7};
    vecs[15] = '{32'hEC00_0030, 3'b111, 4, 6'd48};
    vecs[16] = '{32'hFC00_0003, 3'b000, 4, 6'd3};

    // Reset state
    #1;
    check("rst_instr", instruction, 0);
    check("rst_pc", 32'(pc), 0);
    check("rst_issue", 32'(issue), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    #3 rst = 1'b0;
    step();

    // Single-instruction vectors: latency and successor PC
    fill_nop();
    for (int v = 0; v < 17; v++) begin
      status = vecs[v].st;
      load(0, vecs[v].instr);
      pulse_run();
      wait_issue(4, n, got);
      check($sformatf("v%0d_first_issue", v), 32'(got), 1);
      check($sformatf("v%0d_instr", v), instruction, vecs[v].instr);
      wait_issue(20, n, got);
      check($sformatf("v%0d_lat", v), 32'(n), 32'(vecs[v].lat + 1));
      check($sformatf("v%0d_pc", v), 32'(pc), 32'(vecs[v].npc));
      pulse_stop();
      check($sformatf("v%0d_stop_busy", v), 32'(busy), 0);
    end
    status = 3'b000;

    // MOV, ADD, HALT timing
    load(0, 32'h2000_0000);
    load(1, 32'h4000_0000);
    load(2, 32'h1000_0000);
    pulse_run();
    iss_n = 0;
    for (int e = 2; e <= 20; e++) begin
      step();
      if (issue && iss_n < 3) begin iss_e[iss_n] = e; iss_n++; end
      if (e == 17) begin
        check("halt_flag", 32'(halted), 1);
        check("halt_pc", 32'(pc), 2);
        check("halt_instr", instruction, 0);
        check("halt_busy", 32'(busy), 0);
      end
    end
    check("seq_issue_count", 32'(iss_n), 3);
    check("seq_issue0", 32'(iss_e[0]), 2);
    check("seq_issue1", 32'(iss_e[1]), 10);
    check("seq_issue2", 32'(iss_e[2]), 14);

    // CMP then conditional jump, taken and not taken
    load(0, 32'hC000_0000);
    load(1, 32'hE400_0005);
    load(2, 32'h0000_0000);
    status = 3'b001;
    pulse_run();
    for (int k = 0; k < 3; k++) wait_issue(20, n, got);
    check("cjmp_taken_issue", 32'(got), 1);
    check("cjmp_taken_pc", 32'(pc), 5);
    pulse_stop();
    status = 3'b000;
    pulse_run();
    for (int k = 0; k < 3; k++) wait_issue(20, n, got);
    check("cjmp_not_issue", 32'(got), 1);
    check("cjmp_not_pc", 32'(pc), 2);
    pulse_stop();

    // PC wrap from DEPTH-1
    load(63, 32'h4000_0000);
    load(0, 32'hE000_003F);
    pulse_run();
    wait_issue(4, n, got);
    wait_issue(20, n, got);
    check("wrap_at63", 32'(pc), 63);
    wait_issue(20, n, got);
    check("wrap_issue", 32'(got), 1);
    check("wrap_pc0", 32'(pc), 0);
    pulse_stop();

    // stop during the 4th EXEC cycle of a MOV at address 3
    load(0, 32'hE000_0003);
    load(3, 32'h2000_0000);
    pulse_run();
    wait_issue(4, n, got);
    wait_issue(20, n, got);
    step(); step(); step();
    check("stop_pre_busy", 32'(busy), 1);
    pulse_stop();
    check("stop_busy", 32'(busy), 0);
    check("stop_instr", instruction, 0);
    check("stop_pc", 32'(pc), 3);
    check("stop_issue", 32'(issue), 0);
    step();
    check("stop_idle_hold", 32'(busy), 0);

    // run and stop together from IDLE
    run = 1'b1; stop = 1'b1;
    step();
    run = 1'b0; stop = 1'b0;
    check("runstop_busy", 32'(busy), 0);
    step();
    check("runstop_issue", 32'(issue), 0);

    // load_en ignored during EXEC, then async reset mid-EXEC
    load(0, 32'h2000_0000);
    load(1, 32'h1000_0000);
    load(2, 32'h1000_0000);
    pulse_run();
    wait_issue(4, n, got);
    load_en = 1'b1; load_addr = 6'd1; load_data = 32'h4000_0000;
    step(); step();
    load_en = 1'b0;
    check("ar_pre_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_instr", instruction, 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_pc", 32'(pc), 0);
    check("ar_issue", 32'(issue), 0);
    #1 rst = 1'b0;
    pulse_run();
    n = 0;
    while (!halted && n < 40) begin step(); n++; end
    check("exec_load_halted", 32'(halted), 1);
    check("exec_load_pc", 32'(pc), 1);

    // CALL at 4 to 10, RET/jump at 10
    fill_nop();
    load(4, 32'hEC00_000A);
    load(10, 32'hF400_0014);
    load(5, 32'h1000_0000);
    load(20, 32'h1000_0000);
    exp_pcs[0] = 6'd0; exp_pcs[1] = 6'd1; exp_pcs[2] = 6'd2; exp_pcs[3] = 6'd3;
    exp_pcs[4] = 6'd4; exp_pcs[5] = 6'd10;
`ifdef PROG_SEQ_CALL_EN
    exp_pcs[6] = 6'd5;
`else
    exp_pcs[6] = 6'd20;
`endif
    pulse_run();
    for (int k = 0; k < 7; k++) begin
      wait_issue(20, n, got);
      check($sformatf("call_issue%0d", k), 32'(got), 1);
      check($sformatf("call_pc%0d", k), 32'(pc), 32'(exp_pcs[k]));
    end
    n = 0;
    while (!halted && n < 20) begin step(); n++; end
    check("call_halted", 32'(halted), 1);
    check("call_halt_pc", 32'(pc), 32'(exp_pcs[6]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
